cardinal_router_inport: RTL and testbench

CARDINAL_ROUTER_INPORT -- requirements
Module: cardinal_router_inport

---
 rtl/cardinal_router_inport_pkg.sv | 23 ++
 rtl/cardinal_router_inport_vc_slot.sv | 31 +++
 rtl/cardinal_router_inport.sv | 88 ++++++++
 tb/tb_cardinal_router_inport.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cardinal_router_inport_pkg.sv
`default_nettype none
// ============================================================================
// cardinal_router_inport_pkg : shared cardinal NoC constants and VC helpers
// Revision : 1.0
// ============================================================================
package cardinal_router_inport_pkg;

    localparam int PAC_WIDTH_DEFAULT = 64;
    localparam int VC_BIT            = 0;
    localparam int CNT_WIDTH         = 16;

    typedef enum logic {
        VC_EVEN = 1'b0,
        VC_ODD  = 1'b1
    } vc_e;

    // The NIC may inject on the VC the router is not currently draining.
    function automatic vc_e ext_vc_of(input logic pol);
        return pol ? VC_EVEN : VC_ODD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cardinal_router_inport_vc_slot.sv
`default_nettype none
// ============================================================================
// vc_slot : single-entry packet register with full flag for one virtual channel
// Revision : 1.0
// ============================================================================
module vc_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wen,
    input  logic             ren,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
            full <= 1'b0;
        end else if (wen) begin
            dout <= din;
            full <= 1'b1;
        end else if (ren) begin
            full <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cardinal_router_inport.sv
`default_nettype none
// ============================================================================
// cardinal_router_inport : two-VC phase-alternating router input port
// Revision : 1.0
// ============================================================================
module cardinal_router_inport
    import cardinal_router_inport_pkg::*;
#(
    parameter int PAC_WIDTH = PAC_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 polarity,
    input  logic                 up_si,
    output logic                 up_ri,
    input  logic [PAC_WIDTH-1:0] up_di,
    output logic                 dn_so,
    input  logic                 dn_ro,
    output logic [PAC_WIDTH-1:0] dn_do,
    output logic                 vc_err,
    output logic [CNT_WIDTH-1:0] pkt_cnt
);

    logic                 pol;
    logic                 ext_vc;
    logic                 int_vc;
    logic                 accept;
    logic                 drop;
    logic                 bad_vc;
    logic [1:0]           full;
    logic [1:0]           wen;
    logic [1:0]           ren;
    logic [PAC_WIDTH-1:0] slot_q [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            pol <= 1'b0;
        end else begin
            pol <= ~pol;
        end
    end

    assign polarity = pol;
    assign ext_vc   = ext_vc_of(pol);
    assign int_vc   = ~ext_vc;

    // Reset forces the handshake outputs to their idle values before the slots clear.
    assign up_ri  = reset | ~full[ext_vc];
    assign accept = ~reset & up_si & ~full[ext_vc];
    assign drop   = ~reset & up_si & full[ext_vc];
    assign bad_vc = accept & (up_di[VC_BIT] != ext_vc);

    assign dn_so = ~reset & full[int_vc] & dn_ro;
    assign dn_do = slot_q[int_vc];

    for (genvar i = 0; i < 2; i++) begin : g_slot
        assign wen[i] = accept & (ext_vc == (i != 0));
        assign ren[i] = dn_so & (int_vc == (i != 0));

        vc_slot #(
            .WIDTH (PAC_WIDTH)
        ) u_slot (
            .clk   (clk),
            .reset (reset),
            .wen   (wen[i]),
            .ren   (ren[i]),
            .din   (up_di),
            .dout  (slot_q[i]),
            .full  (full[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vc_err  <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            if (drop || bad_vc) begin
                vc_err <= 1'b1;
            end
            if (dn_so) begin
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_router_inport.sv
`default_nettype none
// ============================================================================
// tb_cardinal_router_inport : scoreboard bench with a behavioural port model
// Revision : 1.0
// ============================================================================
module tb_cardinal_router_inport;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        polarity;
    logic        up_si = 1'b0;
    logic        up_ri;
    logic [63:0] up_di = '0;
    logic        dn_so;
    logic        dn_ro = 1'b0;
    logic [63:0] dn_do;
    logic        vc_err;
    logic [15:0] pkt_cnt;

    cardinal_router_inport #(.PAC_WIDTH(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .up_si    (up_si),
        .up_ri    (up_ri),
        .up_di    (up_di),
        .dn_so    (dn_so),
        .dn_ro    (dn_ro),
        .dn_do    (dn_do),
        .vc_err   (vc_err),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk_state;
        bit          up_ri;
        bit          dn_so;
        bit          pol;
        bit          err;
        int          cnt;
        logic [63:0] dout;
    } exp_t;

    exp_t expq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: phase bit, two one-packet slots, sticky error, counter.
    bit          mp;
    bit          merr;
    bit          mfull [2];
    logic [63:0] mbuf  [2];
    int          mcnt;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step(input bit r, input bit si, input logic [63:0] di, input bit ro);
        exp_t e;
        int   ext;
        int   iv;
        @(posedge clk);
        #1;
        reset = r;
        up_si = si;
        up_di = di;
        dn_ro = ro;
        if (r) begin
            e = '{chk_state: 1'b0, up_ri: 1'b1, dn_so: 1'b0, pol: 1'b0, err: 1'b0, cnt: 0, dout: '0};
            expq.push_back(e);
            mp = 0; merr = 0; mcnt = 0;
            mfull[0] = 0; mfull[1] = 0;
            mbuf[0] = '0; mbuf[1] = '0;
        end else begin
            ext = mp ? 0 : 1;
            iv  = 1 - ext;
            e.chk_state = 1'b1;
            e.pol   = mp;
            e.up_ri = !mfull[ext];
            e.dn_so = mfull[iv] && ro;
            e.err   = merr;
            e.cnt   = mcnt;
            e.dout  = mbuf[iv];
            expq.push_back(e);
            if (e.dn_so) begin
                mfull[iv] = 0;
                mcnt = (mcnt + 1) % 65536;
            end
            if (si) begin
                if (e.up_ri) begin
                    mbuf[ext]  = di;
                    mfull[ext] = 1;
                    if (di[0] != (ext == 1)) merr = 1;
                end else begin
                    merr = 1;
                end
            end
            mp = !mp;
        end
    endtask

    task automatic idle(input int n, input bit ro);
        for (int i = 0; i < n; i++) step(0, 0, '0, ro);
    endtask

    task automatic wait_pol(input bit p, input bit ro);
        while (mp != p) step(0, 0, '0, ro);
    endtask

    function automatic logic [63:0] mk(input logic [62:0] hi, input bit vc);
        return {hi, vc};
    endfunction

    exp_t me;
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            me = expq.pop_front();
            chk("up_ri", 64'(up_ri), 64'(me.up_ri));
            chk("dn_so", 64'(dn_so), 64'(me.dn_so));
            if (me.dn_so) chk("dn_do_fwd", dn_do, me.dout);
            if (me.chk_state) begin
                chk("polarity", 64'(polarity), 64'(me.pol));
                chk("vc_err", 64'(vc_err), 64'(me.err));
                chk("pkt_cnt", 64'(pkt_cnt), 64'(me.cnt));
                chk("dn_do", dn_do, me.dout);
            end
        end
    end

    initial begin
        mp = 0; merr = 0; mcnt = 0;
        mfull[0] = 0; mfull[1] = 0;
        mbuf[0] = '0; mbuf[1] = '0;

        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        idle(4, 0);

        wait_pol(0, 1);
        step(0, 1, 64'h8000_0000_0000_00AA, 1);
        idle(2, 1);

        wait_pol(0, 0);
        step(0, 1, mk(63'h1234_5678_9ABC_DEF0, 1'b1), 0);
        step(0, 1, mk(63'h0FED_CBA9_8765_4321, 1'b0), 0);
        idle(2, 0);
        idle(3, 1);

        wait_pol(0, 0);
        step(0, 1, mk(63'h5555_AAAA_5555_AAAA, 1'b1), 0);
        idle(1, 0);
        step(0, 1, mk(63'h7777_0000_7777_0000, 1'b1), 0);
        idle(3, 1);

        step(1, 0, '0, 0);
        wait_pol(1, 1);
        step(0, 1, mk(63'h0BAD_0BAD_0BAD_0BAD, 1'b1), 1);
        idle(2, 1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0));
        end

        step(1, 0, '0, 0);
        for (int i = 0; i < 65538; i++) begin
            step(0, 1, mk(63'(i), !mp), 1);
        end

        step(0, 1, mk(63'h1111, !mp), 0);
        step(0, 1, mk(63'h2222, !mp), 0);
        idle(1, 0);
        step(1, 0, '0, 1);
        idle(3, 1);

        @(negedge clk);
        #1;
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
